uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter; the transmit-direction counterpart of the receiver path.
- Serialises one parallel byte into an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing comes from an internal 1x baud divider driven by the same 2-bit baudRate code as the receiver's BaudGen.
- Sits between the host/register side and the serial line pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz (bench clock is 20 ns period).
- DATA_BITS, 8, payload width.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- baudRate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 b/s.
- parityMode  input  2  parity select: 00 or 11=none, 01=even, 10=odd.
- twoStop  input  1  1=two stop bits, 0=one stop bit.
- dataIn  input  DATA_BITS  byte to send.
- start  input  1  send request.
- tx  output  1  serial line; idles high.
- ready  output  1  1 = idle, request will be accepted.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: rst sampled 0 at a rising edge forces the following on the next edge, regardless of state:
  - state=IDLE, tx=1, ready=1, done=0;
  - divider and bit counters cleared.
  - Reset mid-frame aborts the frame and the line returns high.
- Divisor is computed per rate as (CLK_FREQ + baud/2)/baud, truncated. At 50 MHz: 2400->20833, 4800->10417, 9600->5208, 19200->2604 clocks per bit.
- Acceptance: start=1 and ready=1 at edge E0.
  - Latch dataIn, baudRate, parityMode and twoStop.
  - At E0: ready->0, tx->0 (start bit), state=START.
  - Later changes on any input are ignored until the next acceptance.
- start while ready=0 is ignored; it is neither queued nor an error.
- Each bit holds tx stable for exactly divisor clocks. The bit counter reloads to divisor-1 and counts down to 0; at 0 the FSM advances.
- FSM sequence, each state one bit period:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=data[i], i=0..DATA_BITS-1, LSB first, shift register.
  - PARITY: entered only when parity is enabled.
    - even: tx = XOR of data bits;
    - odd: tx = inverted XOR.
  - STOP1: tx=1.
  - STOP2: tx=1; entered only if twoStop=1.
  - Then return to IDLE.
- Frame length N = 1 + DATA_BITS + P + S bits, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- Completion: at edge E0 + N*divisor, state=IDLE, ready=1, and done=1 for exactly one cycle. tx stays 1.
- Back-to-back: a start sampled at the next edge (E0 + N*divisor + 1) is accepted. The minimum inter-frame idle is therefore 1 clock beyond the stop bits.
- tx is registered with no combinational path from inputs, so it is glitch-free.
- The divisor counter must be wide enough for 20833, i.e. at least 15 bits.

Test Plan:
- Reset: hold rst=0 for 3 clocks with start=1 -> tx=1, ready=1, done=0, no frame starts. After release, start=1 with dataIn=0x00 -> tx falls on the accepting edge.
- Basic frame, 9600 b/s, parity none, one stop bit, dataIn=0xA5:
  - tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 5208 clocks (104160 ns);
  - done pulses once, 52080 clocks after acceptance;
  - ready is low for the whole frame.
- Parity, 19200 b/s, dataIn=0xA5:
  - even parity -> parity bit 0; odd parity -> parity bit 1.
  - dataIn=0x07 even -> parity bit 1.
  - Frame is 11 bits, each 2604 clocks.
- Two stop bits, 2400 b/s, dataIn=0xFF -> tx high for 2*20833 clocks after the last data bit; done at 11*20833 clocks.
- Robustness, 4800 b/s:
  - change dataIn and baudRate mid-frame, pulse start while busy -> frame uses the latched values, 10417 clocks per bit, no second frame.
  - Assert rst=0 during bit 3 -> tx=1 and ready=1 on the next edge.
- Back-to-back: hold start=1 continuously with 0x55 then 0x3C -> two complete frames, separated by exactly one idle-high clock after the stop bit, with two done pulses.

Source files
------------

// File: rtl/uart_tx.sv
// Purpose : UART transmitter; serialises one byte as start, DATA_BITS LSB-first, optional parity, 1/2 stop bits.
// Latency : tx drops on the accepting edge; done pulses N*divisor clocks later (N = frame bits).
// Backpr. : ready=1 only when idle; start while busy is dropped, never queued.
//
// Ports:
//   clock      - system clock, rising edge
//   rst        - synchronous active-low reset
//   baudRate   - 00=2400, 01=4800, 10=9600, 11=19200 b/s
//   parityMode - 00/11 none, 01 even, 10 odd
//   twoStop    - 1 = two stop bits
//   dataIn     - byte to send, latched on acceptance
//   start      - send request, accepted when ready=1
//   tx         - registered serial line, idles high
//   ready      - idle, next start will be accepted
//   done       - one-cycle pulse as the frame completes
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [1:0]           baudRate,
    input  logic [1:0]           parityMode,
    input  logic                 twoStop,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 start,
    output logic                 tx,
    output logic                 ready,
    output logic                 done
);

    // Clocks per bit, rounded to nearest.
    localparam int DIV_2400  = (CLK_FREQ + 1200) / 2400;
    localparam int DIV_4800  = (CLK_FREQ + 2400) / 4800;
    localparam int DIV_9600  = (CLK_FREQ + 4800) / 9600;
    localparam int DIV_19200 = (CLK_FREQ + 9600) / 19200;

    // Slowest rate sets the counter width; never narrower than 15 bits.
    localparam int CNT_W = ($clog2(DIV_2400) > 15) ? $clog2(DIV_2400) : 15;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Frame configuration captured at acceptance.
    typedef struct packed {
        cnt_t div_m1;
        logic par_en;
        logic par_bit;
        logic two_stop;
    } cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t               state;
    cfg_t                 cfg;
    cnt_t                 cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;

    function automatic cnt_t div_m1_of(input logic [1:0] code);
        cnt_t d;
        case (code)
            2'b00:   d = cnt_t'(DIV_2400 - 1);
            2'b01:   d = cnt_t'(DIV_4800 - 1);
            2'b10:   d = cnt_t'(DIV_9600 - 1);
            default: d = cnt_t'(DIV_19200 - 1);
        endcase
        return d;
    endfunction

    always_ff @(posedge clock) begin
        if (!rst) begin
            state   <= IDLE;
            cfg     <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                // ready is high whenever the FSM is idle, so start alone qualifies.
                if (start) begin
                    cfg.div_m1   <= div_m1_of(baudRate);
                    cfg.par_en   <= (parityMode == 2'b01) || (parityMode == 2'b10);
                    // Odd parity is the inverted XOR of the payload.
                    cfg.par_bit  <= (^dataIn) ^ (parityMode == 2'b10);
                    cfg.two_stop <= twoStop;
                    shreg        <= dataIn;
                    cnt          <= div_m1_of(baudRate);
                    tx           <= 1'b0;
                    ready        <= 1'b0;
                    state        <= START;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - cnt_t'(1);
            end else begin
                // Bit period over: reload and present the next bit.
                cnt <= cfg.div_m1;
                case (state)
                    START: begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (cfg.par_en) begin
                                tx    <= cfg.par_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP1;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                    PARITY: begin
                        tx    <= 1'b1;
                        state <= STOP1;
                    end
                    STOP1: begin
                        if (cfg.two_stop) begin
                            state <= STOP2;
                        end else begin
                            state <= IDLE;
                            ready <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        // STOP2 (and any unreachable encoding) ends the frame.
                        tx    <= 1'b1;
                        state <= IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
